// File: rtl/gpr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_pkg
//  Description : Shared constants and types for the multi-port general-purpose
//                register file: default data width, write-source select codes
//                and the INIT/RUN state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpr_pkg;

    localparam int unsigned GPR_XLEN = 32;

    // Write-data source select
    localparam logic GPR_SRC_ALU = 1'b0;
    localparam logic GPR_SRC_CSR = 1'b1;

    // Register-file controller states
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } gpr_state_e;

endpackage : gpr_pkg
`default_nettype wire

// File: rtl/gpr_bank.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_bank
//  Description : NREG x XLEN register storage, one synchronous write port and
//                one asynchronous read port. One instance backs each read port
//                of the register file; all instances share the write port.
//  Ports       : clk - clock
//                we  - write enable, wa - write address, wd - write data
//                ra  - read address, rd - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_bank
    import gpr_pkg::*;
#(
    parameter int XLEN = GPR_XLEN,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   ra,
    output logic [XLEN-1:0] rd
);

    // Contents are not reset; the controller sweeps zeros in after reset.
    logic [XLEN-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wa] <= wd;
        end
    end

    assign rd = r_mem[ra];

endmodule : gpr_bank
`default_nettype wire

// File: rtl/gpr_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_multiport
//  Description : Parametrised general-purpose register file with NRD read
//                ports and one write port (ALU/MEM or CSR data). Each read
//                port owns a replicated bank. Writes pass through a one-entry
//                commit buffer with read forwarding. After reset a sweep
//                zeroes every entry; gpr_ready rises when it completes.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                gpr_we, gpr_src   - write enable, data select (0 ALU, 1 CSR)
//                gpr_rd            - write address
//                gpr_di, csr_rdata - write data candidates
//                gpr_ra            - packed read addresses, port k [k*AW +: AW]
//                gpr_q             - packed read data, port k [k*XLEN +: XLEN]
//                gpr_ready         - sweep complete, reads valid
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_multiport
    import gpr_pkg::*;
#(
    parameter int XLEN    = GPR_XLEN,
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gpr_we,
    input  logic                gpr_src,
    input  logic [AW-1:0]       gpr_rd,
    input  logic [XLEN-1:0]     gpr_di,
    input  logic [XLEN-1:0]     csr_rdata,
    input  logic [NRD*AW-1:0]   gpr_ra,
    output logic [NRD*XLEN-1:0] gpr_q,
    output logic                gpr_ready
);

    localparam logic [AW-1:0] c_last_idx = AW'(NREG - 1);

    gpr_state_e      r_state;
    gpr_state_e      w_state_nxt;
    logic [AW-1:0]   r_idx;

    logic            r_buf_valid;
    logic [AW-1:0]   r_buf_addr;
    logic [XLEN-1:0] r_buf_data;

    logic            w_run;
    logic [XLEN-1:0] w_wdata;
    logic            w_rd_zero;
    logic            w_cap;

    logic            w_bank_we;
    logic [AW-1:0]   w_bank_wa;
    logic [XLEN-1:0] w_bank_wd;

    assign w_run     = (r_state == ST_RUN);
    assign w_wdata   = (gpr_src == GPR_SRC_CSR) ? csr_rdata : gpr_di;
    assign w_rd_zero = (ZERO_R0 != 0) && (gpr_rd == '0);
    // A write is accepted only in RUN and only if it is not aimed at a hardwired x0.
    assign w_cap     = w_run && gpr_we && !w_rd_zero;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_idx == c_last_idx) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_idx       <= '0;
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_run) begin
                r_idx <= r_idx + AW'(1);
            end
            // Buffer always reflects the most recent accepted write, so a
            // committing older value can never hide a newer one.
            r_buf_valid <= w_cap;
            if (w_cap) begin
                r_buf_addr <= gpr_rd;
                r_buf_data <= w_wdata;
            end
        end
    end

    assign gpr_ready = w_run;

    // Shared bank write port: zero sweep in INIT, buffer commit in RUN.
    // Blocked while rst is high so a pending commit is discarded.
    assign w_bank_we = !rst && (!w_run || r_buf_valid);
    assign w_bank_wa = w_run ? r_buf_addr : r_idx;
    assign w_bank_wd = w_run ? r_buf_data : '0;

    // ------------------------------------------------ per-port bank + mux
    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_bank_q;

        assign w_ra = gpr_ra[k*AW +: AW];

        gpr_bank #(
            .XLEN (XLEN),
            .NREG (NREG),
            .AW   (AW)
        ) u_bank (
            .clk (clk),
            .we  (w_bank_we),
            .wa  (w_bank_wa),
            .wd  (w_bank_wd),
            .ra  (w_ra),
            .rd  (w_bank_q)
        );

        assign gpr_q[k*XLEN +: XLEN] =
            !w_run                                  ? '0         :
            ((ZERO_R0 != 0) && (w_ra == '0))        ? '0         :
            ((BYPASS != 0) && w_cap && (gpr_rd == w_ra)) ? w_wdata :
            (r_buf_valid && (r_buf_addr == w_ra))   ? r_buf_data :
                                                      w_bank_q;
    end : g_port

endmodule : gpr_multiport
`default_nettype wire

// File: tb/tb_gpr_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpr_multiport
//  Description : Directed bench for gpr_multiport. Three instances: default
//                config with BYPASS=0, default config with BYPASS=1, and a
//                4-port / 16-register / ZERO_R0=0 variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_multiport;

    logic clk;
    logic rst;

    // Shared stimulus for the two default-config instances
    logic        we, src;
    logic [4:0]  rd;
    logic [31:0] di, csr;
    logic [9:0]  ra;
    logic [63:0] q_b0, q_b1;
    logic        rdy_b0, rdy_b1;

    // Stimulus for the 4-port instance
    logic         we_p;
    logic [3:0]   rd_p;
    logic [31:0]  di_p, csr_p;
    logic [15:0]  ra_p;
    logic [127:0] q_p;
    logic         rdy_p;

    int checks;
    int errors;

    gpr_multiport #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .ZERO_R0(1), .BYPASS(0)) dut_b0 (
        .clk(clk), .rst(rst), .gpr_we(we), .gpr_src(src), .gpr_rd(rd), .gpr_di(di),
        .csr_rdata(csr), .gpr_ra(ra), .gpr_q(q_b0), .gpr_ready(rdy_b0)
    );

    gpr_multiport #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .ZERO_R0(1), .BYPASS(1)) dut_b1 (
        .clk(clk), .rst(rst), .gpr_we(we), .gpr_src(src), .gpr_rd(rd), .gpr_di(di),
        .csr_rdata(csr), .gpr_ra(ra), .gpr_q(q_b1), .gpr_ready(rdy_b1)
    );

    gpr_multiport #(.XLEN(32), .NREG(16), .AW(4), .NRD(4), .ZERO_R0(0), .BYPASS(1)) dut_p (
        .clk(clk), .rst(rst), .gpr_we(we_p), .gpr_src(1'b0), .gpr_rd(rd_p), .gpr_di(di_p),
        .csr_rdata(csr_p), .gpr_ra(ra_p), .gpr_q(q_p), .gpr_ready(rdy_p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "timeout");
    end

    // Advance to 1 time unit after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 32; c++) begin
            #3;
            checks++;
            if (rdy_b0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready_b0 cycle %0d: got %b expected 0", c, rdy_b0);
            end
            checks++;
            if (rdy_p !== (c >= 16)) begin
                errors++;
                $display("FAIL reset_ready_p cycle %0d: got %b expected %b", c, rdy_p, (c >= 16));
            end
            checks++;
            if (q_b0 !== 64'h0 || q_b1 !== 64'h0) begin
                errors++;
                $display("FAIL reset_q_init cycle %0d: got %h/%h expected 0", c, q_b0, q_b1);
            end
            tick();
        end
        #3;
        checks++;
        if (rdy_b0 !== 1'b1 || rdy_b1 !== 1'b1 || rdy_p !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_end: got %b%b%b expected 111", rdy_b0, rdy_b1, rdy_p);
        end
        tick();
        for (int a = 0; a < 32; a++) begin
            logic [4:0] a5;
            logic [3:0] a4;
            a5 = 5'(a);
            a4 = 4'(a);
            ra   = {a5, a5};
            ra_p = {a4, a4, a4, a4};
            #3;
            checks++;
            if (q_b0 !== 64'h0 || q_b1 !== 64'h0) begin
                errors++;
                $display("FAIL reset_zero_read x%0d: got %h/%h expected 0", a, q_b0, q_b1);
            end
            if (a < 16) begin
                checks++;
                if (q_p !== 128'h0) begin
                    errors++;
                    $display("FAIL reset_zero_read_p x%0d: got %h expected 0", a, q_p);
                end
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic();
        we = 1'b1; src = 1'b0; rd = 5'd5; di = 32'hDEADBEEF; ra = {5'd0, 5'd5};
        #3;
        checks++;
        if (q_b0[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL basic_write_cycle_nobypass: got %h expected 00000000", q_b0[31:0]);
        end
        checks++;
        if (q_b1[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_write_cycle_bypass: got %h expected deadbeef", q_b1[31:0]);
        end
        tick();
        we = 1'b0; di = 32'h0;
        for (int c = 0; c < 2; c++) begin
            #3;
            checks++;
            if (q_b0[31:0] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL basic_read_after t+%0d: got %h expected deadbeef", c + 1, q_b0[31:0]);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_csr_x0();
        we = 1'b1; src = 1'b1; rd = 5'd7; csr = 32'h12345678; di = 32'hFFFFFFFF; ra = {5'd7, 5'd7};
        tick();
        we = 1'b0; src = 1'b0;
        #3;
        checks++;
        if (q_b0 !== {2{32'h12345678}}) begin
            errors++;
            $display("FAIL csr_src_x7: got %h expected 1234567812345678", q_b0);
        end
        tick();
        we = 1'b1; rd = 5'd0; di = 32'hAAAAAAAA; ra = {5'd0, 5'd0};
        #3;
        checks++;
        if (q_b1 !== 64'h0) begin
            errors++;
            $display("FAIL x0_bypass: got %h expected 0", q_b1);
        end
        tick();
        we = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #3;
            checks++;
            if (q_b0 !== 64'h0 || q_b1 !== 64'h0) begin
                errors++;
                $display("FAIL x0_after_write +%0d: got %h/%h expected 0", c + 1, q_b0, q_b1);
            end
            tick();
        end
        ra = {5'd7, 5'd7};
        #3;
        checks++;
        if (q_b1 !== {2{32'h12345678}}) begin
            errors++;
            $display("FAIL csr_src_x7_bank: got %h expected 1234567812345678", q_b1);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [31:0] exp_b1 [5];
        logic [31:0] exp_b0 [5];
        exp_b1 = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
        exp_b0 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd3};
        ra = {5'd3, 5'd3}; src = 1'b0; rd = 5'd3;
        for (int c = 0; c < 5; c++) begin
            we = (c < 3);
            di = (c < 3) ? 32'(c + 1) : 32'h0;
            #3;
            checks++;
            if (q_b1 !== {exp_b1[c], exp_b1[c]}) begin
                errors++;
                $display("FAIL b2b_bypass cycle %0d: got %h expected %h%h", c, q_b1, exp_b1[c], exp_b1[c]);
            end
            checks++;
            if (q_b0 !== {exp_b0[c], exp_b0[c]}) begin
                errors++;
                $display("FAIL b2b_nobypass cycle %0d: got %h expected %h%h", c, q_b0, exp_b0[c], exp_b0[c]);
            end
            tick();
        end
        we = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        we = 1'b1; src = 1'b0; rd = 5'd9; di = 32'h55; ra = {5'd9, 5'd9};
        tick();
        // Commit cycle: buffered x9 would reach the banks at this edge.
        we = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        we = 1'b1; di = 32'h77;
        for (int c = 0; c < 32; c++) begin
            #3;
            checks++;
            if (rdy_b0 !== 1'b0 || q_b1 !== 64'h0) begin
                errors++;
                $display("FAIL mid_reset_init cycle %0d: ready %b q %h expected 0/0", c, rdy_b0, q_b1);
            end
            tick();
        end
        we = 1'b0; di = 32'h0;
        for (int c = 0; c < 2; c++) begin
            #3;
            checks++;
            if (rdy_b0 !== 1'b1 || q_b0 !== 64'h0 || q_b1 !== 64'h0) begin
                errors++;
                $display("FAIL mid_reset_x9 +%0d: ready %b q %h/%h expected 1/0/0", c, rdy_b0, q_b0, q_b1);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_param();
        logic [3:0]  addr [4];
        logic [31:0] val  [4];
        addr = '{4'd0, 4'd1, 4'd2, 4'd15};
        val  = '{32'h100, 32'h111, 32'h222, 32'hF0F};
        for (int c = 0; c < 4; c++) begin
            we_p = 1'b1; rd_p = addr[c]; di_p = val[c];
            tick();
        end
        we_p = 1'b0; di_p = 32'h0;
        ra_p = {addr[0], addr[1], addr[2], addr[3]};
        tick();
        #3;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (q_p[k*32 +: 32] !== val[3-k]) begin
                errors++;
                $display("FAIL param_port%0d x%0d: got %h expected %h", k, addr[3-k], q_p[k*32 +: 32], val[3-k]);
            end
        end
        tick();
        // x0 writable: read it back on every port
        ra_p = 16'h0;
        #3;
        checks++;
        if (q_p !== {4{32'h100}}) begin
            errors++;
            $display("FAIL param_x0_all_ports: got %h expected %h", q_p, {4{32'h100}});
        end
        tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; we = 1'b0; src = 1'b0; rd = '0; di = '0; csr = '0; ra = '0;
        we_p = 1'b0; rd_p = '0; di_p = '0; csr_p = '0; ra_p = '0;
        test_reset();
        test_basic();
        test_csr_x0();
        test_back_to_back();
        test_mid_reset();
        test_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_gpr_multiport
`default_nettype wire
